// File: rtl/pbit_pkg.sv
// rtl/pbit_pkg.sv - shared types, constants and saturating shift for the p-bit row engine
package pbit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [15:0] LFSR_MASK   = 16'hB400;
    // Per-cell seed stride so neighbouring p-bits start decorrelated
    localparam logic [15:0] SEED_STRIDE = 16'h9E37;

    // v <<< sh evaluated at 64 bits, then clipped to the signed w-bit range.
    // The result is returned sign-extended to 32 bits.
    function automatic logic signed [31:0] sat_shl(input logic signed [31:0] v,
                                                   input logic [4:0]         sh,
                                                   input int                 w);
        logic signed [63:0] wide;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        wide = {{32{v[31]}}, v} <<< sh;
        hi   = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo   = -(64'sd1 <<< (w - 1));
        if (wide > hi) begin
            sat_shl = hi[31:0];
        end else if (wide < lo) begin
            sat_shl = lo[31:0];
        end else begin
            sat_shl = wide[31:0];
        end
    endfunction

endpackage

// File: rtl/pbit_cell.sv
// rtl/pbit_cell.sv - one probabilistic bit: LFSR, beta scaling, compare, clamp and state register
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   adv_en_i        advance the LFSR this cycle (engine is running)
//   update_en_i     this cell's colour slot is active; m_o may change
//   field_i         signed local field
//   shift_i         beta exponent applied to field_i
//   clamp_en_i      force clamp_val_i instead of the stochastic decision
//   clamp_val_i     forced value
//   m_o             registered p-bit state
module pbit_cell
    import pbit_pkg::*;
#(
    parameter int          FIELD_W = 8,
    parameter int          SHIFT_W = 3,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      adv_en_i,
    input  logic                      update_en_i,
    input  logic signed [FIELD_W-1:0] field_i,
    input  logic        [SHIFT_W-1:0] shift_i,
    input  logic                      clamp_en_i,
    input  logic                      clamp_val_i,
    output logic                      m_o
);

    logic [15:0]               lfsr_q;
    logic [15:0]               lfsr_d;
    logic                      m_q;
    logic                      m_d;
    logic signed [31:0]        s_full;
    logic signed [FIELD_W-1:0] r_val;
    logic                      fire;

    // Random compare value comes from the state before this cycle's advance
    assign r_val  = lfsr_q[FIELD_W-1:0];
    assign s_full = sat_shl(32'(field_i), 5'(shift_i), FIELD_W);
    // s_full is already inside the FIELD_W range, so a 32-bit compare is exact
    assign fire   = (s_full > 32'(r_val));

    always_comb begin
        lfsr_d = lfsr_q;
        if (adv_en_i) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
        end
    end

    always_comb begin
        m_d = m_q;
        if (update_en_i) begin
            m_d = clamp_en_i ? clamp_val_i : fire;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
            m_q    <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            m_q    <= m_d;
        end
    end

    assign m_o = m_q;

endmodule

// File: rtl/pbit_row_engine.sv
// rtl/pbit_row_engine.sv - row of p-bits swept in colour groups under a start/done handshake
//
// Optional build macro: PBIT_ANNEAL_EN (beta exponent ramps by one per completed sweep)
//
// Ports:
//   clk, reset      clock and asynchronous active-high reset
//   start           request a run (accepted only when idle)
//   halt            abort a run in progress, no done pulse
//   n_sweeps        full sweeps to execute, captured when start is accepted
//   bit_shift       beta exponent (live, or anneal start value)
//   field           packed signed local fields, FIELD_W per p-bit
//   clamp_mask      per-bit clamp enable
//   clamp_val       per-bit clamp value
//   m               p-bit states
//   busy            running
//   done            one-cycle completion pulse
//   phase           active colour group
//   sweep_cnt       completed sweeps in the current or last run
module pbit_row_engine
    import pbit_pkg::*;
#(
    parameter int          N_COLS     = 8,
    parameter int          FIELD_W    = 8,
    parameter int          NUM_PHASES = 5,
    parameter int          SWEEP_W    = 16,
    parameter int          SHIFT_W    = 3,
    parameter logic [15:0] SEED_BASE  = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        halt,
    input  logic [SWEEP_W-1:0]          n_sweeps,
    input  logic [SHIFT_W-1:0]          bit_shift,
    input  logic [N_COLS*FIELD_W-1:0]   field,
    input  logic [N_COLS-1:0]           clamp_mask,
    input  logic [N_COLS-1:0]           clamp_val,
    output logic [N_COLS-1:0]           m,
    output logic                        busy,
    output logic                        done,
    output logic [(NUM_PHASES > 1 ? $clog2(NUM_PHASES) : 1)-1:0] phase,
    output logic [SWEEP_W-1:0]          sweep_cnt
);

    localparam int PH_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

    state_e             state_q;
    state_e             state_d;
    logic [PH_W-1:0]    phase_q;
    logic [PH_W-1:0]    phase_d;
    logic [SWEEP_W-1:0] sweep_q;
    logic [SWEEP_W-1:0] sweep_d;
    logic [SWEEP_W-1:0] nsw_q;
    logic [SWEEP_W-1:0] nsw_d;
    logic               running;
    logic               run_active;
    logic               wrap;
    logic [SHIFT_W-1:0] shift_eff;

    assign running    = (state_q == ST_RUN);
    // The halt cycle still advances the LFSRs but freezes every p-bit
    assign run_active = running & ~halt;
    assign wrap       = (phase_q == PH_W'(NUM_PHASES - 1));

`ifdef PBIT_ANNEAL_EN
    logic [SHIFT_W-1:0] anneal_q;
    logic [SHIFT_W-1:0] anneal_d;

    always_comb begin
        anneal_d = anneal_q;
        if (state_q == ST_IDLE && start) begin
            anneal_d = bit_shift;
        end else if (run_active && wrap && anneal_q != {SHIFT_W{1'b1}}) begin
            anneal_d = anneal_q + SHIFT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anneal_q <= '0;
        end else begin
            anneal_q <= anneal_d;
        end
    end

    assign shift_eff = anneal_q;
`else
    assign shift_eff = bit_shift;
`endif

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        sweep_d = sweep_q;
        nsw_d   = nsw_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    nsw_d   = n_sweeps;
                    phase_d = '0;
                    sweep_d = '0;
                    state_d = (n_sweeps == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                end else if (wrap) begin
                    phase_d = '0;
                    sweep_d = sweep_q + SWEEP_W'(1);
                    if (sweep_q + SWEEP_W'(1) == nsw_q) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            sweep_q <= '0;
            nsw_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            sweep_q <= sweep_d;
            nsw_q   <= nsw_d;
        end
    end

    for (genvar i = 0; i < N_COLS; i++) begin : g_cell
        localparam logic [15:0] SEED_RAW = SEED_BASE ^ 16'(i * SEED_STRIDE);
        // An all-zero Galois LFSR would lock up
        localparam logic [15:0] SEED     = (SEED_RAW == 16'h0000) ? 16'h0001 : SEED_RAW;

        logic upd;
        assign upd = run_active & (phase_q == PH_W'(i % NUM_PHASES));

        pbit_cell #(
            .FIELD_W (FIELD_W),
            .SHIFT_W (SHIFT_W),
            .SEED    (SEED)
        ) u_cell (
            .clk         (clk),
            .rst         (reset),
            .adv_en_i    (running),
            .update_en_i (upd),
            .field_i     (field[i*FIELD_W +: FIELD_W]),
            .shift_i     (shift_eff),
            .clamp_en_i  (clamp_mask[i]),
            .clamp_val_i (clamp_val[i]),
            .m_o         (m[i])
        );
    end

    assign busy      = running;
    assign done      = (state_q == ST_DONE);
    assign phase     = phase_q;
    assign sweep_cnt = sweep_q;

endmodule
